// File: rtl/tgdemux_deser.sv
`default_nettype none
// ============================================================================
// Module   : tgdemux_deser
// Purpose  : Receiving end of the SEL-driven 2:1 transmission-gate mux path.
//            Demultiplexes a time-multiplexed sample stream (one slot per
//            CLK cycle, SYNC marks slot 0) into N parallel lanes and presents
//            each completed frame with a VALID/ACK handshake.
// Ports    : CLK    - rising-edge clock, one slot per cycle
//            RST    - synchronous, active-high reset
//            EN     - capture enable; low = stream ignored, slot pointer holds
//            SYNC   - high in the cycle D carries slot 0
//            D      - serial sample stream, W bits
//            ACK    - downstream accepts the current frame
//            SEL    - index of the slot captured this cycle
//            Q      - lane outputs, lane k at Q[k*W +: W]
//            VALID  - Q holds a complete, unacknowledged frame
//            OVF    - sticky: a completed frame was dropped while VALID pending
//            SERR   - sticky: SYNC seen at a non-zero slot mid-frame
//            FRAMES - committed-frame counter (only with TGDEMUX_FRAME_CNT_EN)
// Options  : define TGDEMUX_FRAME_CNT_EN to add the FRAMES[15:0] output.
// Revision : 1.0 - initial release
// ============================================================================
module tgdemux_deser #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EN,
    input  logic                   SYNC,
    input  logic [W-1:0]           D,
    input  logic                   ACK,
    output logic [$clog2(N)-1:0]   SEL,
    output logic [N*W-1:0]         Q,
    output logic                   VALID,
    output logic                   OVF,
    output logic                   SERR
`ifdef TGDEMUX_FRAME_CNT_EN
    ,
    output logic [15:0]            FRAMES
`endif
);

    localparam int            SW        = $clog2(N);
    localparam logic [SW-1:0] c_LAST    = SW'(N - 1);
    localparam logic [SW-1:0] c_FIRST   = SW'(1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;

    logic [1:0]           r_state;
    logic [SW-1:0]        r_sel;
    // The last slot goes straight from D into Q on the completion edge, so
    // only the first N-1 slots need holding.
    logic [(N-1)*W-1:0]   r_shadow;
    logic [N*W-1:0]       r_q;
    logic                 r_valid;
    logic                 r_ovf;
    logic                 r_serr;

    logic [1:0]           w_state_nxt;
    logic [SW-1:0]        w_sel_nxt;
    logic                 w_cap;
    logic [SW-1:0]        w_cap_idx;
    logic                 w_serr_set;
    logic                 w_last;
    logic                 w_commit;
    logic                 w_drop;
    logic [N*W-1:0]       w_frame;

    // ------------------------------------------------------------------
    // Next-state / capture control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cap       = 1'b0;
        w_cap_idx   = r_sel;
        w_serr_set  = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_sel_nxt = '0;
                if (EN && SYNC) begin
                    w_cap       = 1'b1;
                    w_cap_idx   = '0;
                    w_sel_nxt   = c_FIRST;
                    w_state_nxt = c_CAPTURE;
                end
            end
            c_CAPTURE: begin
                if (EN) begin
                    if (SYNC && (r_sel != '0)) begin
                        // Resync: the partial frame is abandoned and this
                        // sample becomes slot 0 of a fresh frame.
                        w_serr_set = 1'b1;
                        w_cap      = 1'b1;
                        w_cap_idx  = '0;
                        w_sel_nxt  = c_FIRST;
                    end else if (r_sel == c_LAST) begin
                        w_last      = 1'b1;
                        w_sel_nxt   = '0;
                        w_state_nxt = c_DONE;
                    end else begin
                        w_cap     = 1'b1;
                        w_sel_nxt = r_sel + c_FIRST;
                    end
                end
            end
            c_DONE: begin
                // Back-to-back frames start here with no idle gap.
                w_sel_nxt   = '0;
                w_state_nxt = c_IDLE;
                if (EN && SYNC) begin
                    w_cap       = 1'b1;
                    w_cap_idx   = '0;
                    w_sel_nxt   = c_FIRST;
                    w_state_nxt = c_CAPTURE;
                end
            end
            default: begin
                w_sel_nxt   = '0;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign w_frame  = {D, r_shadow};
    assign w_commit = w_last && (!r_valid || ACK);
    assign w_drop   = w_last && r_valid && !ACK;

    // ------------------------------------------------------------------
    // State and slot pointer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Shadow lanes
    // ------------------------------------------------------------------
    for (genvar k = 0; k < N - 1; k++) begin : g_lane
        localparam logic [SW-1:0] c_IDX = SW'(k);
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_shadow[k*W +: W] <= '0;
            end else if (w_cap && (w_cap_idx == c_IDX)) begin
                r_shadow[k*W +: W] <= D;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output frame, handshake and sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q     <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_serr  <= 1'b0;
        end else begin
            if (w_commit) begin
                r_q     <= w_frame;
                r_valid <= 1'b1;
            end else if (ACK) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_serr_set) begin
                r_serr <= 1'b1;
            end
        end
    end

`ifdef TGDEMUX_FRAME_CNT_EN
    logic [15:0] r_frames;

    // Only committed frames count; wraps naturally at 16 bits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_frames <= '0;
        end else if (w_commit) begin
            r_frames <= r_frames + 16'd1;
        end
    end

    assign FRAMES = r_frames;
`endif

    assign SEL   = r_sel;
    assign Q     = r_q;
    assign VALID = r_valid;
    assign OVF   = r_ovf;
    assign SERR  = r_serr;

endmodule
`default_nettype wire

// File: tb/tb_tgdemux_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_tgdemux_deser
// Purpose  : Directed self-checking bench for tgdemux_deser. A 2-slot
//            instance covers single frames, streaming, overflow, EN gaps and
//            mid-frame reset; a 4-slot instance covers resync.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tgdemux_deser;

    logic        clk;
    logic        rst;

    logic        en, sync, ack;
    logic [7:0]  d;
    logic        sel;
    logic [15:0] q;
    logic        valid, ovf, serr;

    logic        en4, sync4, ack4;
    logic [7:0]  d4;
    logic [1:0]  sel4;
    logic [31:0] q4;
    logic        valid4, ovf4, serr4;

`ifdef TGDEMUX_FRAME_CNT_EN
    logic [15:0] frames, frames4;
`endif

    int checks = 0;
    int errors = 0;

    tgdemux_deser #(.N(2), .W(8)) u_dut2 (
        .CLK   (clk),
        .RST   (rst),
        .EN    (en),
        .SYNC  (sync),
        .D     (d),
        .ACK   (ack),
        .SEL   (sel),
        .Q     (q),
        .VALID (valid),
        .OVF   (ovf),
        .SERR  (serr)
`ifdef TGDEMUX_FRAME_CNT_EN
        ,
        .FRAMES(frames)
`endif
    );

    tgdemux_deser #(.N(4), .W(8)) u_dut4 (
        .CLK   (clk),
        .RST   (rst),
        .EN    (en4),
        .SYNC  (sync4),
        .D     (d4),
        .ACK   (ack4),
        .SEL   (sel4),
        .Q     (q4),
        .VALID (valid4),
        .OVF   (ovf4),
        .SERR  (serr4)
`ifdef TGDEMUX_FRAME_CNT_EN
        ,
        .FRAMES(frames4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sync = 1'b0; d = 8'h00; ack = 1'b0;
        en4 = 1'b0; sync4 = 1'b0; d4 = 8'h00; ack4 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_sel",   64'(sel),   64'h0);
        chk("rst_q",     64'(q),     64'h0);
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_ovf",   64'(ovf),   64'h0);
        chk("rst_serr",  64'(serr),  64'h0);

        // Single frame 0x11, 0x22
        en = 1'b1; sync = 1'b1; d = 8'h11;
        tick();
        chk("single_sel1", 64'(sel), 64'h1);
        chk("single_valid_mid", 64'(valid), 64'h0);
        sync = 1'b0; d = 8'h22;
        tick();
        chk("single_sel0",  64'(sel),   64'h0);
        chk("single_valid", 64'(valid), 64'h1);
        chk("single_q",     64'(q),     64'h2211);
        chk("single_ovf",   64'(ovf),   64'h0);
        chk("single_serr",  64'(serr),  64'h0);

        // Back-to-back streaming with ACK held high
        ack = 1'b1;
        sync = 1'b1; d = 8'hA1; tick();
        chk("stream_a_ack_clears", 64'(valid), 64'h0);
        sync = 1'b0; d = 8'hA2; tick();
        chk("stream_a_q",     64'(q),     64'hA2A1);
        chk("stream_a_valid", 64'(valid), 64'h1);
        sync = 1'b1; d = 8'hB1; tick();
        sync = 1'b0; d = 8'hB2; tick();
        chk("stream_b_q",     64'(q),     64'hB2B1);
        chk("stream_b_valid", 64'(valid), 64'h1);
        chk("stream_ovf",     64'(ovf),   64'h0);

        // Drain, then overflow with ACK low
        d = 8'h00; tick();
        chk("drain_valid", 64'(valid), 64'h0);
        ack = 1'b0;
        sync = 1'b1; d = 8'h01; tick();
        sync = 1'b0; d = 8'h02; tick();
        chk("ovf_first_q",   64'(q),   64'h0201);
        chk("ovf_first_ovf", 64'(ovf), 64'h0);
        sync = 1'b1; d = 8'h03; tick();
        sync = 1'b0; d = 8'h04; tick();
        chk("ovf_q_kept", 64'(q),     64'h0201);
        chk("ovf_valid",  64'(valid), 64'h1);
        chk("ovf_flag",   64'(ovf),   64'h1);
        ack = 1'b1; d = 8'h00; tick();
        ack = 1'b0;
        chk("ovf_ack_valid", 64'(valid), 64'h0);
        chk("ovf_sticky",    64'(ovf),   64'h1);

        // EN gap between slot 0 and slot 1
        sync = 1'b1; d = 8'h55; tick();
        en = 1'b0; sync = 1'b0; d = 8'h99;
        tick(); tick(); tick();
        chk("engap_sel_hold", 64'(sel),   64'h1);
        chk("engap_valid",    64'(valid), 64'h0);
        en = 1'b1; d = 8'h66; tick();
        chk("engap_q",     64'(q),     64'h6655);
        chk("engap_valid2", 64'(valid), 64'h1);

        // Reset mid-frame after slot 0 captured
        sync = 1'b1; d = 8'h12; tick();
        chk("midrst_sel_before", 64'(sel), 64'h1);
        rst = 1'b1; sync = 1'b0; d = 8'h00; tick();
        rst = 1'b0;
        chk("midrst_sel",   64'(sel),   64'h0);
        chk("midrst_q",     64'(q),     64'h0);
        chk("midrst_valid", 64'(valid), 64'h0);
        chk("midrst_ovf",   64'(ovf),   64'h0);
        chk("midrst_serr",  64'(serr),  64'h0);
        sync = 1'b1; d = 8'h7E; tick();
        sync = 1'b0; d = 8'h7F; tick();
        chk("postrst_q",     64'(q),     64'h7F7E);
        chk("postrst_valid", 64'(valid), 64'h1);
`ifdef TGDEMUX_FRAME_CNT_EN
        chk("postrst_frames", 64'(frames), 64'h1);
`endif
        en = 1'b0;

        // Resync on the 4-slot instance
        en4 = 1'b1; sync4 = 1'b1; d4 = 8'h10; tick();
        sync4 = 1'b0; d4 = 8'h20; tick();
        chk("resync_sel2", 64'(sel4), 64'h2);
        sync4 = 1'b1; d4 = 8'h30; tick();
        chk("resync_serr", 64'(serr4),  64'h1);
        chk("resync_sel1", 64'(sel4),   64'h1);
        chk("resync_valid", 64'(valid4), 64'h0);
        sync4 = 1'b0; d4 = 8'h40; tick();
        d4 = 8'h50; tick();
        chk("resync_sel3", 64'(sel4), 64'h3);
        d4 = 8'h60; tick();
        chk("resync_q",      64'(q4),     64'h60504030);
        chk("resync_valid2", 64'(valid4), 64'h1);
        chk("resync_sel0",   64'(sel4),   64'h0);
        chk("resync_sticky", 64'(serr4),  64'h1);
        chk("resync_ovf",    64'(ovf4),   64'h0);
`ifdef TGDEMUX_FRAME_CNT_EN
        chk("resync_frames", 64'(frames4), 64'h1);
`endif
        en4 = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
